// File: rtl/sys_ctrl_pkg.sv
// Shared register map and bit positions for the 0xF000 system control block.
// Firmware register header is generated from these definitions.
package sys_ctrl_pkg;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h1;
    localparam logic [3:0] OFF_RELOAD  = 4'h2;
    localparam logic [3:0] OFF_COUNT   = 4'h3;
    localparam logic [3:0] OFF_CYC_LO  = 4'h4;
    localparam logic [3:0] OFF_CYC_HI  = 4'h5;
    localparam logic [3:0] OFF_SCRATCH = 4'h6;

    localparam int unsigned CTRL_CPU_RESET   = 0;
    localparam int unsigned CTRL_TMR_EN      = 1;
    localparam int unsigned CTRL_AUTO_RELOAD = 2;
    localparam int unsigned CTRL_IRQ_EN      = 3;

    localparam int unsigned STAT_EXPIRED   = 0;
    localparam int unsigned STAT_CPU_RESET = 1;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    function automatic logic [15:0] pack_ctrl(input logic cpu_reset, input logic tmr_en,
                                              input logic auto_reload, input logic irq_en);
        logic [15:0] v;
        v = '0;
        v[CTRL_CPU_RESET]   = cpu_reset;
        v[CTRL_TMR_EN]      = tmr_en;
        v[CTRL_AUTO_RELOAD] = auto_reload;
        v[CTRL_IRQ_EN]      = irq_en;
        return v;
    endfunction

    function automatic logic [15:0] pack_status(input logic expired, input logic cpu_reset);
        logic [15:0] v;
        v = '0;
        v[STAT_EXPIRED]   = expired;
        v[STAT_CPU_RESET] = cpu_reset;
        return v;
    endfunction

endpackage

// File: rtl/sys_ctrl_timer.sv
// Prescaled 16-bit countdown timer: prescaler, COUNT register and expiry/reload.
// Pulse outputs are combinational and valid in the tick cycle.
module ctrl_timer #(
    parameter int unsigned PRESCALE = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic [15:0] reload_i,
    input  logic        auto_reload_i,
    output logic [15:0] count_o,
    output logic        expire_pulse_o,
    output logic        disable_pulse_o
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [15:0] count_q, count_d;
    logic        tick;

    assign tick    = en_i && (presc_q == PRESC_LAST);
    assign count_o = count_q;

    always_comb begin
        presc_d         = presc_q + 16'd1;
        count_d         = count_q;
        expire_pulse_o  = 1'b0;
        disable_pulse_o = 1'b0;

        if (!en_i || load_i || tick) begin
            presc_d = '0;
        end

        // A bus load overrides the tick entirely: no decrement and no expiry.
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 16'd1;
            end else begin
                expire_pulse_o = 1'b1;
                if (auto_reload_i) begin
                    count_d = reload_i;
                end else begin
                    disable_pulse_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sys_ctrl.sv
// System control block at BASE: CPU reset hold, countdown timer with IRQ,
// 32-bit cycle counter, scratch register and a 1-cycle registered read port.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter logic [3:0]  BASE     = 4'hF,
    parameter int unsigned PRESCALE = 12,
    parameter logic        RST_HOLD = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic [15:0] raddr,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        cpu_reset,
    output logic        irq
);

    logic       wr_hit, rd_hit;
    logic [3:0] woff, roff;
    logic       wr_ctrl, wr_status, wr_reload, wr_count, wr_scratch;
    logic       unused_addr_bits;

    assign woff       = waddr[3:0];
    assign roff       = raddr[3:0];
    assign wr_hit     = we && (waddr[15:12] == BASE);
    assign rd_hit     = re && (raddr[15:12] == BASE);
    assign wr_ctrl    = wr_hit && (woff == OFF_CTRL);
    assign wr_status  = wr_hit && (woff == OFF_STATUS);
    assign wr_reload  = wr_hit && (woff == OFF_RELOAD);
    assign wr_count   = wr_hit && (woff == OFF_COUNT);
    assign wr_scratch = wr_hit && (woff == OFF_SCRATCH);
    assign unused_addr_bits = ^{waddr[11:4], raddr[11:4]};

    tmr_state_e  state_q, state_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        auto_reload_q, auto_reload_d;
    logic        irq_en_q, irq_en_d;
    logic        expired_q, expired_d;
    logic        irq_q, irq_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] cyc_hi_q, cyc_hi_d;
    logic [15:0] rdata_q, rdata_d;
    logic [31:0] cycle_q;
    logic        tmr_en;
    logic [15:0] count;
    logic        expire_pulse, disable_pulse;
    logic [15:0] rd_val;

    // The FSM state register doubles as CTRL.tmr_en.
    assign tmr_en = (state_q == TMR_RUN);

    ctrl_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .clk_i          (clk),
        .rst_ni         (reset_n),
        .en_i           (tmr_en),
        .load_i         (wr_count),
        .load_val_i     (wdata),
        .reload_i       (reload_q),
        .auto_reload_i  (auto_reload_q),
        .count_o        (count),
        .expire_pulse_o (expire_pulse),
        .disable_pulse_o(disable_pulse)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            TMR_IDLE: begin
                if (wr_ctrl && wdata[CTRL_TMR_EN]) begin
                    state_d = TMR_RUN;
                end
            end
            TMR_RUN: begin
                // A bus write to CTRL takes precedence over the one-shot auto-clear.
                if (wr_ctrl) begin
                    state_d = wdata[CTRL_TMR_EN] ? TMR_RUN : TMR_IDLE;
                end else if (disable_pulse) begin
                    state_d = TMR_IDLE;
                end
            end
            default: state_d = TMR_IDLE;
        endcase
    end

    always_comb begin
        cpu_reset_d   = cpu_reset_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        reload_d      = reload_q;
        scratch_d     = scratch_q;

        if (wr_ctrl) begin
            cpu_reset_d   = wdata[CTRL_CPU_RESET];
            auto_reload_d = wdata[CTRL_AUTO_RELOAD];
            irq_en_d      = wdata[CTRL_IRQ_EN];
        end
        if (wr_reload) begin
            reload_d = wdata;
        end
        if (wr_scratch) begin
            scratch_d = wdata;
        end

        expired_d = expire_pulse || (expired_q && !(wr_status && wdata[STAT_EXPIRED]));
        irq_d     = expired_q && irq_en_q;
    end

    always_comb begin
        rd_val = '0;
        case (roff)
            OFF_CTRL:    rd_val = pack_ctrl(cpu_reset_q, tmr_en, auto_reload_q, irq_en_q);
            OFF_STATUS:  rd_val = pack_status(expired_q, cpu_reset_q);
            OFF_RELOAD:  rd_val = reload_q;
            OFF_COUNT:   rd_val = count;
            OFF_CYC_LO:  rd_val = cycle_q[15:0];
            OFF_CYC_HI:  rd_val = cyc_hi_q;
            OFF_SCRATCH: rd_val = scratch_q;
            default:     rd_val = '0;
        endcase

        rdata_d  = rdata_q;
        cyc_hi_d = cyc_hi_q;
        if (rd_hit) begin
            rdata_d = rd_val;
            if (roff == OFF_CYC_LO) begin
                cyc_hi_d = cycle_q[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= TMR_IDLE;
            cpu_reset_q   <= RST_HOLD;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            expired_q     <= 1'b0;
            irq_q         <= 1'b0;
            reload_q      <= '0;
            scratch_q     <= '0;
            cyc_hi_q      <= '0;
            rdata_q       <= '0;
            cycle_q       <= '0;
        end else begin
            state_q       <= state_d;
            cpu_reset_q   <= cpu_reset_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            expired_q     <= expired_d;
            irq_q         <= irq_d;
            reload_q      <= reload_d;
            scratch_q     <= scratch_d;
            cyc_hi_q      <= cyc_hi_d;
            rdata_q       <= rdata_d;
            cycle_q       <= cycle_q + 32'd1;
        end
    end

    assign rdata     = rdata_q;
    assign cpu_reset = cpu_reset_q;
    assign irq       = irq_q;

endmodule
